reaction_ctrl: RTL and testbench

Top-level sequencer for the reaction-timer game. It drives the ten-LED start-light FSM with its trigger and step ticks and watches the light FSM's "all lit" and random-delay "time out" indications. It measures the player's reaction time in milliseconds from lights-out to button press, flags jump starts, and keeps the best valid time since reset.

---
 rtl/reaction_ctrl.sv | 178 +++++++++++++++++
 tb/tb_reaction_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: top-level sequencer for the reaction-timer game.
// Drives the start-light FSM and measures reaction time in ms.
module reaction_ctrl #(
   parameter int CLK_PER_MS = 50000,
   parameter int LIGHT_MS   = 500,
   parameter int MAX_MS     = 9999
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_btn,
   input  logic        react_btn,
   input  logic        lights_full,
   input  logic        delay_done,
   output logic        light_trigger,
   output logic        light_tick,
   output logic [13:0] react_ms,
   output logic [13:0] best_ms,
   output logic        result_valid,
   output logic        jump_start,
   output logic        busy
);

   localparam int MSW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam int LTW = (LIGHT_MS > 1) ? $clog2(LIGHT_MS) : 1;
   localparam logic [MSW-1:0] MS_LAST = MSW'(CLK_PER_MS - 1);
   localparam logic [LTW-1:0] LT_LAST = LTW'(LIGHT_MS - 1);
   localparam logic [13:0]    MAX_V   = 14'(MAX_MS);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      SEQ,
      HOLD,
      TIMING,
      FOUL,
      DONE
   } state_t;

   state_t state;
   state_t next_state;

   logic           start_q;
   logic           react_q;
   logic           start_rise;
   logic           react_rise;
   logic [MSW-1:0] ms_cnt;
   logic [LTW-1:0] light_cnt;
   logic           ms_tick;
   logic           light_wrap;
   logic           tick_q;
   logic           hold_tick;
   logic           ms_clr;
   logic           light_clr;
   logic           ms_run;
   logic           light_run;
   logic           changing;
   logic [13:0]    react_inc;
   logic           timeout;

   assign start_rise = start_btn & ~start_q;
   assign react_rise = react_btn & ~react_q;
   assign light_tick = tick_q | hold_tick;

   always_comb begin
      changing   = (next_state != state);
      ms_run     = state inside {SEQ, HOLD, TIMING, FOUL};
      light_run  = state inside {SEQ, FOUL};
      ms_tick    = ms_run && (ms_cnt == MS_LAST);
      light_wrap = light_run && ms_tick && (light_cnt == LT_LAST);
      react_inc  = react_ms + 14'd1;
      timeout    = ms_tick && (react_inc >= MAX_V);
      ms_clr     = (state == ARM) ||
                   (changing && (next_state inside {SEQ, TIMING, FOUL}));
      light_clr  = (state == ARM) ||
                   (changing && (next_state == FOUL));
   end

   always_comb begin
      next_state = state;
      hold_tick  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start_rise) next_state = ARM;
         end
         ARM: begin
            next_state = SEQ;
         end
         SEQ: begin
            if (react_rise) next_state = FOUL;
            else if (lights_full) next_state = HOLD;
         end
         HOLD: begin
            if (react_rise) begin
               next_state = FOUL;
            end else if (delay_done) begin
               // lights out is signalled in the sampling cycle itself
               hold_tick  = 1'b1;
               next_state = TIMING;
            end
         end
         TIMING: begin
            if (react_rise || timeout) next_state = DONE;
         end
         FOUL: begin
            if (tick_q && delay_done) next_state = DONE;
         end
         DONE: begin
            if (start_rise) next_state = ARM;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         start_q <= 1'b0;
         react_q <= 1'b0;
      end else begin
         state   <= next_state;
         start_q <= start_btn;
         react_q <= react_btn;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ms_cnt    <= '0;
         light_cnt <= '0;
         tick_q    <= 1'b0;
      end else begin
         if (ms_clr || ms_tick) ms_cnt <= '0;
         else if (ms_run) ms_cnt <= ms_cnt + 1'b1;

         if (light_clr) light_cnt <= '0;
         else if (light_wrap) light_cnt <= '0;
         else if (light_run && ms_tick) light_cnt <= light_cnt + 1'b1;

         tick_q <= light_wrap && !changing;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         light_trigger <= 1'b0;
         busy          <= 1'b0;
      end else begin
         light_trigger <= (next_state == SEQ);
         busy          <= !(next_state inside {IDLE, DONE});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         react_ms     <= '0;
         best_ms      <= MAX_V;
         result_valid <= 1'b0;
         jump_start   <= 1'b0;
      end else if (next_state == ARM && changing) begin
         react_ms     <= '0;
         result_valid <= 1'b0;
         jump_start   <= 1'b0;
      end else if (next_state == FOUL && changing) begin
         jump_start <= 1'b1;
      end else if (state == TIMING) begin
         if (react_rise) begin
            result_valid <= 1'b1;
            if (react_ms < best_ms) best_ms <= react_ms;
         end else if (ms_tick) begin
            react_ms <= (react_inc >= MAX_V) ? MAX_V : react_inc;
            if (timeout) result_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_reaction_ctrl.sv
// tb_reaction_ctrl: directed game scenarios with randomized press times,
// checked against a ms-arithmetic model of the reaction timer.
module tb_reaction_ctrl;

   localparam int CPM   = 4;
   localparam int LMS   = 2;
   localparam int MAXMS = 20;
   localparam int TICK  = CPM * LMS;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start_btn = 1'b0;
   logic        react_btn = 1'b0;
   logic        lights_full = 1'b0;
   logic        delay_done = 1'b0;
   logic        light_trigger;
   logic        light_tick;
   logic [13:0] react_ms;
   logic [13:0] best_ms;
   logic        result_valid;
   logic        jump_start;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int best_model = MAXMS;
   int n;
   int k;

   reaction_ctrl #(
      .CLK_PER_MS(CPM),
      .LIGHT_MS  (LMS),
      .MAX_MS    (MAXMS)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start_btn    (start_btn),
      .react_btn    (react_btn),
      .lights_full  (lights_full),
      .delay_done   (delay_done),
      .light_trigger(light_trigger),
      .light_tick   (light_tick),
      .react_ms     (react_ms),
      .best_ms      (best_ms),
      .result_valid (result_valid),
      .jump_start   (jump_start),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_tick(input int limit, output int cnt);
      cnt = 0;
      do begin
         step();
         cnt++;
      end while (!light_tick && cnt < limit);
      if (!light_tick) cnt = -1;
   endtask

   task automatic start_game();
      start_btn = 1'b1;
      step();
      chk("arm_busy", busy, 1);
      chk("arm_trigger", light_trigger, 0);
      start_btn = 1'b0;
      step();
      chk("seq_trigger", light_trigger, 1);
   endtask

   task automatic to_hold();
      lights_full = 1'b1;
      step();
      chk("hold_trigger", light_trigger, 0);
      chk("hold_busy", busy, 1);
   endtask

   task automatic lights_out();
      delay_done = 1'b1;
      #1;
      chk("lights_out_tick", light_tick, 1);
      step();
      chk("timing_tick_low", light_tick, 0);
      delay_done  = 1'b0;
      lights_full = 1'b0;
   endtask

   // base = cycles already spent in TIMING; press sampled at base+cyc
   task automatic press_at(input int base, input int cyc);
      int exp_ms;
      repeat (cyc) step();
      react_btn = 1'b1;
      step();
      react_btn = 1'b0;
      exp_ms = (base + cyc) / CPM;
      if (exp_ms < best_model) best_model = exp_ms;
      chk("press_react_ms", react_ms, exp_ms);
      chk("press_valid", result_valid, 1);
      chk("press_busy", busy, 0);
      chk("press_jump", jump_start, 0);
      chk("press_best", best_ms, best_model);
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_trigger"}, light_trigger, 0);
      chk({tag, "_tick"}, light_tick, 0);
      chk({tag, "_react"}, react_ms, 0);
      chk({tag, "_best"}, best_ms, MAXMS);
      chk({tag, "_valid"}, result_valid, 0);
      chk({tag, "_jump"}, jump_start, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      step();
      step();
      check_reset_vals("reset");
      rst_n = 1'b1;
      repeat (3) step();
      chk("idle_busy", busy, 0);
      chk("idle_trigger", light_trigger, 0);

      // normal run: ten light ticks, then a ~13 ms reaction
      start_game();
      for (int i = 0; i < 10; i++) begin
         wait_tick(40, n);
         chk("seq_tick_spacing", n, TICK);
      end
      to_hold();
      lights_out();
      press_at(0, 52 + int'($urandom_range(0, 3)));
      chk("run1_best13", best_ms, 13);

      // slower second run; a start press mid-TIMING is ignored
      start_game();
      to_hold();
      lights_out();
      start_btn = 1'b1;
      step();
      start_btn = 1'b0;
      press_at(1, 67 + int'($urandom_range(0, 3)));
      chk("run2_react17", react_ms, 17);
      chk("run2_best_kept", best_ms, 13);

      // jump start in HOLD
      start_game();
      to_hold();
      react_btn = 1'b1;
      step();
      react_btn = 1'b0;
      chk("foul_jump", jump_start, 1);
      chk("foul_busy", busy, 1);
      chk("foul_react", react_ms, 0);
      chk("foul_valid", result_valid, 0);
      wait_tick(40, n);
      chk("foul_tick1", n, TICK);
      chk("foul_still_busy", busy, 1);
      step();
      delay_done = 1'b1;
      wait_tick(40, n);
      chk("foul_tick2", n, TICK - 1);
      step();
      delay_done  = 1'b0;
      lights_full = 1'b0;
      chk("foul_done_busy", busy, 0);
      chk("foul_done_jump", jump_start, 1);
      chk("foul_done_react", react_ms, 0);
      chk("foul_done_valid", result_valid, 0);
      chk("foul_done_best", best_ms, best_model);

      // delay_done and react rise in the same HOLD cycle
      start_game();
      to_hold();
      react_btn  = 1'b1;
      delay_done = 1'b1;
      #1;
      chk("tie_no_tick", light_tick, 0);
      step();
      react_btn = 1'b0;
      chk("tie_jump", jump_start, 1);
      n = 0;
      while (busy && n < 40) begin
         step();
         n++;
      end
      chk("tie_done_cycles", n, TICK + 1);
      delay_done  = 1'b0;
      lights_full = 1'b0;

      // timeout with no press
      start_game();
      to_hold();
      lights_out();
      repeat (MAXMS * CPM - 1) step();
      chk("tmo_pre_react", react_ms, MAXMS - 1);
      chk("tmo_pre_busy", busy, 1);
      step();
      chk("tmo_react", react_ms, MAXMS);
      chk("tmo_valid", result_valid, 1);
      chk("tmo_busy", busy, 0);
      chk("tmo_best", best_ms, best_model);
      react_btn = 1'b1;
      step();
      react_btn = 1'b0;
      step();
      chk("done_ignore_react", react_ms, MAXMS);
      chk("done_ignore_busy", busy, 0);

      // randomized reaction times, including the first TIMING cycle
      for (int r = 0; r < 6; r++) begin
         k = (r == 0) ? 0 : int'($urandom_range(0, MAXMS * CPM - 1));
         start_game();
         to_hold();
         lights_out();
         press_at(0, k);
      end

      // reset pulsed mid-TIMING
      start_game();
      to_hold();
      lights_out();
      repeat (30) step();
      rst_n = 1'b0;
      #1;
      check_reset_vals("midreset");
      best_model = MAXMS;
      step();
      rst_n = 1'b1;
      step();
      chk("post_reset_busy", busy, 0);

      start_game();
      to_hold();
      lights_out();
      press_at(0, int'($urandom_range(0, MAXMS * CPM - 1)));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
